// File: rtl/csr_host_pkg.sv
// Shared types for the CSR host bridge: FSM states,
// the captured command bundle and bus widths.
package csr_host_pkg;

  localparam int CSR_AW = 32;
  localparam int CSR_DW = 32;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WR_GAP,
    READ,
    RESP
  } state_t;

  typedef struct packed {
    logic              write;
    logic              verify;
    logic [CSR_AW-1:0] addr;
    logic [CSR_DW-1:0] wdata;
    logic [CSR_DW-1:0] mask;
  } csr_cmd_t;

endpackage

// File: rtl/csr_host_bridge.sv
// CSR bus initiator: one valid/ready command in, one
// response out, optional write-then-readback check.
module csr_host_bridge
  import csr_host_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic              cmd_verify,
  input  logic [CSR_AW-1:0] cmd_addr,
  input  logic [CSR_DW-1:0] cmd_wdata,
  input  logic [CSR_DW-1:0] cmd_mask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [CSR_DW-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [CSR_AW-1:0] csr_addr,
  output logic [CSR_DW-1:0] csr_wdata,
  output logic              csr_write,
  input  logic [CSR_DW-1:0] csr_rdata,
  output logic [CNT_W-1:0]  txn_count,
  output logic [CNT_W-1:0]  err_count
);

  localparam logic [2:0] LAT_LOAD =
    3'(RD_LATENCY - 1);

  state_t            state, state_n;
  csr_cmd_t          cmd_q;
  logic [CSR_DW-1:0] wdata_q;
  logic [CSR_DW-1:0] rdata_q;
  logic              err_q;
  logic [2:0]        lat_cnt;
  logic [CNT_W-1:0]  txn_q, errc_q;
  logic              accept, consume, rd_done;

  assign cmd_ready = (state == IDLE) & ~rst;
  assign rsp_valid = (state == RESP);
  assign csr_write = (state == WRITE);
  assign accept    = cmd_valid & cmd_ready;
  assign consume   = rsp_valid & rsp_ready;
  assign rd_done   = (state == READ) &&
                     (lat_cnt == '0);

  assign csr_addr  = cmd_q.addr;
  assign csr_wdata = wdata_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign txn_count = txn_q;
  assign err_count = errc_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (cmd_valid)
          state_n = cmd_write ? WRITE : READ;
      WRITE:
        state_n = WR_GAP;
      WR_GAP:
        state_n = cmd_q.verify ? READ : RESP;
      READ:
        if (lat_cnt == '0) state_n = RESP;
      RESP:
        if (rsp_ready) state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
  end

  // csr_wdata only follows writes so reads leave it untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      lat_cnt <= '0;
      txn_q   <= '0;
      errc_q  <= '0;
    end else begin
      if (accept) begin
        cmd_q <= '{write:  cmd_write,
                   verify: cmd_verify,
                   addr:   cmd_addr,
                   wdata:  cmd_wdata,
                   mask:   cmd_mask};
        if (cmd_write) wdata_q <= cmd_wdata;
      end
      lat_cnt <= (state == READ) ?
                 lat_cnt - 3'd1 : LAT_LOAD;
      if (state == WR_GAP && !cmd_q.verify) begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
      if (rd_done) begin
        rdata_q <= csr_rdata;
        err_q   <= cmd_q.write &
                   |((csr_rdata ^ cmd_q.wdata) &
                     cmd_q.mask);
      end
      if (consume) begin
        txn_q <= txn_q + 1'b1;
        if (err_q) errc_q <= errc_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_csr_host_bridge.sv
// Directed bench: two bridges (read latency 1 and 3),
// each driving a small CONTROL-register target model.
module tb_csr_host_bridge;
  import csr_host_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        a_cmd_valid, a_cmd_ready, a_cmd_write;
  logic        a_cmd_verify, a_rsp_valid, a_rsp_ready;
  logic        a_rsp_err, a_csr_write;
  logic [31:0] a_cmd_addr, a_cmd_wdata, a_cmd_mask;
  logic [31:0] a_rsp_rdata, a_csr_addr, a_csr_wdata;
  logic [31:0] a_csr_rdata;
  logic [15:0] a_txn, a_errc;

  logic        b_cmd_valid, b_cmd_ready, b_cmd_write;
  logic        b_cmd_verify, b_rsp_valid, b_rsp_ready;
  logic        b_rsp_err, b_csr_write;
  logic [31:0] b_cmd_addr, b_cmd_wdata, b_cmd_mask;
  logic [31:0] b_rsp_rdata, b_csr_addr, b_csr_wdata;
  logic [31:0] b_csr_rdata;
  logic [15:0] b_txn, b_errc;

  csr_host_bridge #(.RD_LATENCY(1), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst),
    .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
    .cmd_write(a_cmd_write), .cmd_verify(a_cmd_verify),
    .cmd_addr(a_cmd_addr), .cmd_wdata(a_cmd_wdata),
    .cmd_mask(a_cmd_mask),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
    .csr_addr(a_csr_addr), .csr_wdata(a_csr_wdata),
    .csr_write(a_csr_write), .csr_rdata(a_csr_rdata),
    .txn_count(a_txn), .err_count(a_errc)
  );

  csr_host_bridge #(.RD_LATENCY(3), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_write(b_cmd_write), .cmd_verify(b_cmd_verify),
    .cmd_addr(b_cmd_addr), .cmd_wdata(b_cmd_wdata),
    .cmd_mask(b_cmd_mask),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .csr_addr(b_csr_addr), .csr_wdata(b_csr_wdata),
    .csr_write(b_csr_write), .csr_rdata(b_csr_rdata),
    .txn_count(b_txn), .err_count(b_errc)
  );

  // Target: CONTROL at 0x0, 5 bits; other addresses read 0
  logic [4:0]  a_ctrl, b_ctrl;
  logic [31:0] b_p1, b_p2;

  function automatic logic [31:0] rd_map(
    input logic [31:0] ad, input logic [4:0] c);
    return (ad == 32'h0) ? {27'd0, c} : 32'h0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      a_ctrl <= '0;
      b_ctrl <= '0;
      b_p1   <= '0;
      b_p2   <= '0;
    end else begin
      if (a_csr_write && a_csr_addr == 32'h0)
        a_ctrl <= a_csr_wdata[4:0];
      if (b_csr_write && b_csr_addr == 32'h0)
        b_ctrl <= b_csr_wdata[4:0];
      b_p1 <= rd_map(b_csr_addr, b_ctrl);
      b_p2 <= b_p1;
    end
  end

  assign a_csr_rdata = rd_map(a_csr_addr, a_ctrl);
  assign b_csr_rdata = b_p2;

  int a_wr_n = 0, b_wr_n = 0;
  int a_wr_cyc = 0, b_wr_cyc = 0;
  logic [31:0] a_wr_d = '0, b_wr_d = '0;

  always @(negedge clk) begin
    if (a_csr_write) begin
      a_wr_n++; a_wr_cyc = cyc; a_wr_d = a_csr_wdata;
    end
    if (b_csr_write) begin
      b_wr_n++; b_wr_cyc = cyc; b_wr_d = b_csr_wdata;
    end
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h",
                  nm, act, exp);
  endtask

  typedef struct {
    bit          sel;
    bit          w;
    bit          vf;
    logic [31:0] ad;
    logic [31:0] wd;
    logic [31:0] mk;
    logic [31:0] xd;
    bit          xe;
    int          xlat;
    int          xpul;
  } vec_t;

  function automatic logic rdy(input bit s);
    return s ? b_cmd_ready : a_cmd_ready;
  endfunction
  function automatic logic rv(input bit s);
    return s ? b_rsp_valid : a_rsp_valid;
  endfunction

  task automatic drive(input bit s, input logic v,
                       input logic w, input logic vf,
                       input logic [31:0] ad,
                       input logic [31:0] wd,
                       input logic [31:0] mk);
    if (s) begin
      b_cmd_valid = v; b_cmd_write = w;
      b_cmd_verify = vf; b_cmd_addr = ad;
      b_cmd_wdata = wd; b_cmd_mask = mk;
    end else begin
      a_cmd_valid = v; a_cmd_write = w;
      a_cmd_verify = vf; a_cmd_addr = ad;
      a_cmd_wdata = wd; a_cmd_mask = mk;
    end
  endtask

  task automatic send(input bit s, input logic w,
                      input logic vf,
                      input logic [31:0] ad,
                      input logic [31:0] wd,
                      input logic [31:0] mk,
                      output int acc);
    int n = 0;
    drive(s, 1'b1, w, vf, ad, wd, mk);
    while (!rdy(s) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("accept_wait", 32'(n < 50), 32'd1);
    @(posedge clk); #1;
    acc = cyc;
    drive(s, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic get_rsp(input bit s, input int acc,
                         output logic [31:0] d,
                         output logic e,
                         output int lat);
    int n = 0;
    while (!rv(s) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("rsp_wait", 32'(n < 50), 32'd1);
    lat = cyc - acc + 1;
    d = s ? b_rsp_rdata : a_rsp_rdata;
    e = s ? b_rsp_err : a_rsp_err;
    @(posedge clk); #1;
  endtask

  vec_t tv[12];
  int exp_txn[2];
  int exp_err[2];

  initial begin
    #500000;
    $display("FAIL watchdog: no finish, 0 expected");
    $fatal(1);
  end

  initial begin
    int acc, lat, p, wc, i0;
    logic [31:0] d, wdd, d0, ad0;
    logic e;
    bit s;

    tv[0]  = '{0,1,0,32'h0,32'h5,32'h0,
               32'h0,0,3,1};
    tv[1]  = '{0,0,0,32'h0,32'h0,32'h0,
               32'h5,0,2,0};
    tv[2]  = '{0,1,1,32'h0,32'h3,32'h1F,
               32'h3,0,4,1};
    tv[3]  = '{0,1,1,32'h0,32'hFFFF_FFFF,
               32'hFFFF_FFFF,32'h1F,1,4,1};
    tv[4]  = '{0,1,1,32'h0,32'hFFFF_FFFF,
               32'h1F,32'h1F,0,4,1};
    tv[5]  = '{0,0,0,32'h4,32'h0,32'h0,
               32'h0,0,2,0};
    tv[6]  = '{0,1,1,32'h0,32'h2A,32'h20,
               32'h0A,1,4,1};
    tv[7]  = '{0,0,0,32'h0,32'h0,32'h0,
               32'h0A,0,2,0};
    tv[8]  = '{1,1,0,32'h0,32'h5,32'h0,
               32'h0,0,3,1};
    tv[9]  = '{1,0,0,32'h0,32'h0,32'h0,
               32'h5,0,4,0};
    tv[10] = '{1,1,1,32'h0,32'h13,32'h1F,
               32'h13,0,6,1};
    tv[11] = '{1,0,0,32'h0,32'h0,32'h0,
               32'h13,0,4,0};
    exp_txn[0] = 0; exp_txn[1] = 0;
    exp_err[0] = 0; exp_err[1] = 0;

    drive(0, 0, 0, 0, '0, '0, '0);
    drive(1, 0, 0, 0, '0, '0, '0);
    a_rsp_ready = 1'b1;
    b_rsp_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(a_cmd_ready), 0);
    chk("rst_cmd_ready_b", 32'(b_cmd_ready), 0);
    chk("rst_rsp_valid", 32'(a_rsp_valid), 0);
    chk("rst_rsp_err", 32'(a_rsp_err), 0);
    chk("rst_rsp_rdata", a_rsp_rdata, 0);
    chk("rst_csr_addr", a_csr_addr, 0);
    chk("rst_csr_wdata", a_csr_wdata, 0);
    chk("rst_csr_write", 32'(a_csr_write), 0);
    chk("rst_txn", 32'(a_txn), 0);
    chk("rst_err", 32'(a_errc), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(a_cmd_ready), 1);

    for (int i = 0; i < 12; i++) begin
      s = tv[i].sel;
      p = s ? b_wr_n : a_wr_n;
      send(s, tv[i].w, tv[i].vf, tv[i].ad,
           tv[i].wd, tv[i].mk, acc);
      get_rsp(s, acc, d, e, lat);
      chk($sformatf("v%0d_rdata", i), d, tv[i].xd);
      chk($sformatf("v%0d_err", i), 32'(e),
          32'(tv[i].xe));
      chk($sformatf("v%0d_latency", i), 32'(lat),
          32'(tv[i].xlat));
      wc  = s ? b_wr_n : a_wr_n;
      chk($sformatf("v%0d_wr_pulses", i),
          32'(wc - p), 32'(tv[i].xpul));
      if (tv[i].xpul == 1) begin
        wc  = s ? b_wr_cyc : a_wr_cyc;
        wdd = s ? b_wr_d : a_wr_d;
        chk($sformatf("v%0d_wr_cycle", i),
            32'(wc - acc + 1), 32'd1);
        chk($sformatf("v%0d_wr_data", i),
            wdd, tv[i].wd);
      end
      exp_txn[s]++;
      if (tv[i].xe) exp_err[s]++;
      chk($sformatf("v%0d_txn", i),
          32'(s ? b_txn : a_txn), 32'(exp_txn[s]));
      chk($sformatf("v%0d_errcnt", i),
          32'(s ? b_errc : a_errc), 32'(exp_err[s]));
    end

    // Backpressure with a second command waiting
    a_rsp_ready = 1'b0;
    send(0, 0, 0, 32'h0, 32'h0, 32'h0, acc);
    i0 = 0;
    while (!a_rsp_valid && i0 < 50) begin
      @(posedge clk); #1; i0++;
    end
    chk("bp_rsp_rdata", a_rsp_rdata, 32'h0A);
    drive(0, 1, 1, 0, 32'h0, 32'h11, 32'h0);
    d0  = a_rsp_rdata;
    ad0 = a_csr_addr;
    p   = a_wr_n;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp_rsp_valid", 32'(a_rsp_valid), 1);
      chk("bp_rdata_hold", a_rsp_rdata, d0);
      chk("bp_cmd_ready", 32'(a_cmd_ready), 0);
      chk("bp_addr_hold", a_csr_addr, ad0);
      chk("bp_no_write", 32'(a_wr_n), 32'(p));
    end
    a_rsp_ready = 1'b1;
    @(posedge clk); #1;
    exp_txn[0]++;
    chk("bp_consumed", 32'(a_rsp_valid), 0);
    chk("bp_ready_again", 32'(a_cmd_ready), 1);
    chk("bp_txn", 32'(a_txn), 32'(exp_txn[0]));
    @(posedge clk); #1;
    acc = cyc;
    drive(0, 0, 0, 0, '0, '0, '0);
    chk("bp_second_write", 32'(a_csr_write), 1);
    chk("bp_second_wdata", a_csr_wdata, 32'h11);
    get_rsp(0, acc, d, e, lat);
    chk("bp_second_rdata", d, 32'h0);
    chk("bp_second_lat", 32'(lat), 32'd3);

    // Reset while the verified write sits in WR_GAP
    send(0, 1, 1, 32'h0, 32'h15, 32'h1F, acc);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    p = a_wr_n;
    chk("mid_rst_ready", 32'(a_cmd_ready), 0);
    chk("mid_rst_rsp_valid", 32'(a_rsp_valid), 0);
    chk("mid_rst_rdata", a_rsp_rdata, 0);
    chk("mid_rst_err", 32'(a_rsp_err), 0);
    chk("mid_rst_addr", a_csr_addr, 0);
    chk("mid_rst_wdata", a_csr_wdata, 0);
    chk("mid_rst_write", 32'(a_csr_write), 0);
    chk("mid_rst_txn", 32'(a_txn), 0);
    chk("mid_rst_errcnt", 32'(a_errc), 0);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("mid_rst_no_rsp", 32'(a_rsp_valid), 0);
    end
    chk("mid_rst_no_write", 32'(a_wr_n), 32'(p));
    chk("mid_rst_idle", 32'(a_cmd_ready), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
